// File: rtl/mul_seq_ctrl_if.sv
// Narrow pin bundle between a host and the mul_seq_ctrl multiply sequencer.
// The host drives start and the x/y operand digits; the sequencer returns product nibbles.
interface mul_seq_ctrl_if;
    logic       start;
    logic [1:0] x;
    logic [1:0] y;
    logic [3:0] p;
    logic       s;
    logic       rdy;
    logic       busy;

    modport master (
        output start, x, y,
        input  p, s, rdy, busy
    );

    modport slave (
        input  start, x, y,
        output p, s, rdy, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a WIDTH x WIDTH radix-4 shift-add multiply over 2-bit operand pins and a 4-bit product pin.
// Define MULS_SIGNED_EN for two's-complement operands with a sign output; otherwise operands are unsigned and s is tied 0.
module mul_seq_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus
);

    localparam int D  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int KW = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUL,
        OUT
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   res_q, res_d;
    logic [3:0]      p_q, p_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;

    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] y_shift;
    logic [1:0]       y_digit;
    logic [PW-1:0]    partial;

`ifdef MULS_SIGNED_EN
    logic s_q, s_d;
    logic neg;

    // The datapath multiplies magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
    assign x_mag  = x_q[WIDTH-1] ? (~x_q + WIDTH'(1)) : x_q;
    assign y_mag  = y_q[WIDTH-1] ? (~y_q + WIDTH'(1)) : y_q;
    assign neg    = x_q[WIDTH-1] ^ y_q[WIDTH-1];
    assign result = neg ? (~acc_q + PW'(1)) : acc_q;
    assign bus.s  = s_q;
`else
    assign x_mag  = x_q;
    assign y_mag  = y_q;
    assign result = acc_q;
    assign bus.s  = 1'b0;
`endif

    assign y_shift = y_mag >> (2 * int'(k_q));
    assign y_digit = y_shift[1:0];
    assign partial = PW'(x_mag) * PW'(y_digit);

    assign bus.p    = p_q;
    assign bus.rdy  = rdy_q;
    assign bus.busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            p_q     <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MULS_SIGNED_EN
            s_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            p_q     <= p_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
`ifdef MULS_SIGNED_EN
            s_q     <= s_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        res_d   = res_q;
        p_d     = p_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
`ifdef MULS_SIGNED_EN
        s_d     = s_q;
`endif

        case (state_q)
            IDLE: begin
                // Digit 0 zero-extends, so stale operand bits from the previous job never leak in.
                if (bus.start) begin
                    x_d     = {{(WIDTH-2){1'b0}}, bus.x};
                    y_d     = {{(WIDTH-2){1'b0}}, bus.y};
                    k_d     = KW'(1);
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                x_d = x_q | (WIDTH'(bus.x) << (2 * int'(k_q)));
                y_d = y_q | (WIDTH'(bus.y) << (2 * int'(k_q)));
                k_d = k_q + KW'(1);
                if (k_q == KW'(D - 1)) begin
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = MUL;
                end
            end

            MUL: begin
                acc_d = acc_q + (partial << (2 * int'(k_q)));
                k_d   = k_q + KW'(1);
                if (k_q == KW'(D - 1)) begin
                    k_d     = '0;
                    state_d = OUT;
                end
            end

            OUT: begin
                // k == D is the drain edge that drops rdy after the last nibble has been shown for a full cycle.
                if (k_q == KW'(D)) begin
                    k_d     = '0;
                    p_d     = '0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef MULS_SIGNED_EN
                    s_d     = 1'b0;
`endif
                end else if (k_q == '0) begin
                    p_d   = result[3:0];
                    res_d = result >> 4;
                    rdy_d = 1'b1;
                    k_d   = KW'(1);
`ifdef MULS_SIGNED_EN
                    s_d   = result[PW-1];
`endif
                end else begin
                    p_d   = res_q[3:0];
                    res_d = res_q >> 4;
                    k_d   = k_q + KW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed-vector bench for mul_seq_ctrl at WIDTH=6 (three digits, three nibbles).
// Signed cases are compiled in when MULS_SIGNED_EN is defined; unsigned cases otherwise.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mul_seq_ctrl_if bus_if ();

    mul_seq_ctrl #(.WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one job from E0 through E9 and records what the pins showed along the way.
    task automatic run_job(
        input  logic [5:0]  xv,
        input  logic [5:0]  yv,
        input  logic        hold_start,
        output logic [11:0] prod,
        output int          first_rdy,
        output int          rdy_cycles,
        output logic        sgn,
        output logic        busy0,
        output logic        busy_held,
        output logic        busy_end,
        output logic        quiet_ok
    );
        prod       = '0;
        first_rdy  = -1;
        rdy_cycles = 0;
        sgn        = 1'b0;
        busy_held  = 1'b1;
        quiet_ok   = 1'b1;
        bus_if.start = 1'b1;
        bus_if.x     = xv[1:0];
        bus_if.y     = yv[1:0];
        tick();
        busy0 = bus_if.busy;
        bus_if.start = hold_start;
        for (int e = 1; e <= 9; e++) begin
            if (e < 3) begin
                bus_if.x = xv[2*e +: 2];
                bus_if.y = yv[2*e +: 2];
            end else begin
                bus_if.x = 2'b00;
                bus_if.y = 2'b00;
            end
            tick();
            if (bus_if.rdy) begin
                if (first_rdy < 0) first_rdy = e;
                if (rdy_cycles < 3) prod[4*rdy_cycles +: 4] = bus_if.p;
                sgn = sgn | bus_if.s;
                rdy_cycles++;
            end else if (bus_if.p !== 4'h0 || bus_if.s !== 1'b0) begin
                quiet_ok = 1'b0;
            end
            if (e < 9 && bus_if.busy !== 1'b1) busy_held = 1'b0;
        end
        busy_end = bus_if.busy;
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset;
        logic saw_rdy;
        logic saw_busy;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.x = 2'b00;
        bus_if.y = 2'b00;
        tick();
        tick();
        checks++;
        if (bus_if.p !== 4'h0) begin errors++; $display("[TB] FAIL reset p: got %h expected 0", bus_if.p); end
        checks++;
        if (bus_if.s !== 1'b0) begin errors++; $display("[TB] FAIL reset s: got %b expected 0", bus_if.s); end
        checks++;
        if (bus_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset rdy: got %b expected 0", bus_if.rdy); end
        checks++;
        if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", bus_if.busy); end
        rst = 1'b0;
        saw_rdy = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            saw_rdy  = saw_rdy | (bus_if.rdy !== 1'b0);
            saw_busy = saw_busy | (bus_if.busy !== 1'b0);
        end
        checks++;
        if (saw_rdy) begin errors++; $display("[TB] FAIL idle rdy: got 1 expected 0"); end
        checks++;
        if (saw_busy) begin errors++; $display("[TB] FAIL idle busy: got 1 expected 0"); end
    endtask

    task automatic test_mul_5x7;
        logic [11:0] prod;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
        run_job(6'd5, 6'd7, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'h023) begin errors++; $display("[TB] FAIL mul5x7 product: got %h expected 023", prod); end
        checks++;
        if (first_rdy != 6) begin errors++; $display("[TB] FAIL mul5x7 latency: got E%0d expected E6", first_rdy); end
        checks++;
        if (rdy_cycles != 3) begin errors++; $display("[TB] FAIL mul5x7 rdy cycles: got %0d expected 3", rdy_cycles); end
        checks++;
        if (sgn !== 1'b0) begin errors++; $display("[TB] FAIL mul5x7 sign: got %b expected 0", sgn); end
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL mul5x7 busy after E0: got %b expected 1", busy0); end
        checks++;
        if (busy_held !== 1'b1) begin errors++; $display("[TB] FAIL mul5x7 busy during job: got %b expected 1", busy_held); end
        checks++;
        if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL mul5x7 busy at E9: got %b expected 0", busy_end); end
        checks++;
        if (quiet_ok !== 1'b1) begin errors++; $display("[TB] FAIL mul5x7 p/s nonzero while rdy=0: got %b expected 1", quiet_ok); end
    endtask

    task automatic test_mul_max;
        logic [11:0] prod, expected;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
`ifdef MULS_SIGNED_EN
        expected = 12'h001;
`else
        expected = 12'hF81;
`endif
        run_job(6'd63, 6'd63, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== expected) begin errors++; $display("[TB] FAIL mul63x63 product: got %h expected %h", prod, expected); end
        checks++;
        if (first_rdy != 6) begin errors++; $display("[TB] FAIL mul63x63 latency: got E%0d expected E6", first_rdy); end
        checks++;
        if (sgn !== 1'b0) begin errors++; $display("[TB] FAIL mul63x63 sign: got %b expected 0", sgn); end
    endtask

    task automatic test_mul_zero;
        logic [11:0] prod;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
        run_job(6'd0, 6'd45, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'h000) begin errors++; $display("[TB] FAIL mul0x45 product: got %h expected 000", prod); end
        checks++;
        if (rdy_cycles != 3) begin errors++; $display("[TB] FAIL mul0x45 rdy cycles: got %0d expected 3", rdy_cycles); end
    endtask

`ifdef MULS_SIGNED_EN
    task automatic test_signed;
        logic [11:0] prod;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
        run_job(6'b111101, 6'b000101, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'hFF1) begin errors++; $display("[TB] FAIL signed -3x5 product: got %h expected ff1", prod); end
        checks++;
        if (sgn !== 1'b1) begin errors++; $display("[TB] FAIL signed -3x5 sign: got %b expected 1", sgn); end
        run_job(6'b100000, 6'b100000, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'h400) begin errors++; $display("[TB] FAIL signed -32x-32 product: got %h expected 400", prod); end
        checks++;
        if (sgn !== 1'b0) begin errors++; $display("[TB] FAIL signed -32x-32 sign: got %b expected 0", sgn); end
    endtask
`else
    task automatic test_unsigned_wide;
        logic [11:0] prod;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
        run_job(6'b111101, 6'b000101, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'h131) begin errors++; $display("[TB] FAIL mul61x5 product: got %h expected 131", prod); end
        checks++;
        if (sgn !== 1'b0) begin errors++; $display("[TB] FAIL mul61x5 sign: got %b expected 0", sgn); end
    endtask
`endif

    task automatic test_start_held;
        logic [11:0] prod;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
        run_job(6'd5, 6'd7, 1'b1, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'h023) begin errors++; $display("[TB] FAIL held-start product: got %h expected 023", prod); end
        checks++;
        if (rdy_cycles != 3) begin errors++; $display("[TB] FAIL held-start rdy cycles: got %0d expected 3", rdy_cycles); end
        checks++;
        if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL held-start busy at E9: got %b expected 0", busy_end); end
        tick();
        checks++;
        if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL held-start busy after release: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_reset_abort;
        logic [11:0] prod;
        int          first_rdy, rdy_cycles;
        logic        sgn, busy0, busy_held, busy_end, quiet_ok;
        logic        saw_rdy;
        bus_if.start = 1'b1;
        bus_if.x = 2'b01;
        bus_if.y = 2'b11;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort busy: got %b expected 0", bus_if.busy); end
        checks++;
        if (bus_if.rdy !== 1'b0 || bus_if.p !== 4'h0) begin
            errors++; $display("[TB] FAIL abort outputs: got rdy=%b p=%h expected rdy=0 p=0", bus_if.rdy, bus_if.p);
        end
        saw_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_rdy = saw_rdy | (bus_if.rdy !== 1'b0);
        end
        checks++;
        if (saw_rdy) begin errors++; $display("[TB] FAIL abort rdy after reset: got 1 expected 0"); end
        run_job(6'd5, 6'd7, 1'b0, prod, first_rdy, rdy_cycles, sgn, busy0, busy_held, busy_end, quiet_ok);
        checks++;
        if (prod !== 12'h023) begin errors++; $display("[TB] FAIL post-abort product: got %h expected 023", prod); end
        checks++;
        if (first_rdy != 6) begin errors++; $display("[TB] FAIL post-abort latency: got E%0d expected E6", first_rdy); end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.x = 2'b00;
        bus_if.y = 2'b00;
        test_reset();
        test_mul_5x7();
        test_mul_max();
        test_mul_zero();
`ifdef MULS_SIGNED_EN
        test_signed();
`else
        test_unsigned_wide();
`endif
        test_start_held();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
